// File: rtl/fire_pkg.sv
// Shared types and default geometry for the fire expand layer sequencer.
package fire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WAIT_ACK,
    DONE
  } state_e;

  localparam int WOUT_DEF   = 8;
  localparam int CHIN_DEF   = 112;
  localparam int KDIM_DEF   = 3;
  localparam int ADDR_W_DEF = 16;
  localparam int WIN_DEF    = WOUT_DEF + KDIM_DEF - 1;
  localparam int TAPS_DEF   = KDIM_DEF * KDIM_DEF * CHIN_DEF;
  localparam int PIX_DEF    = WOUT_DEF * WOUT_DEF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fire_win_addr_gen.sv
// Walks the 3x3xCHIN window of every output pixel and produces the matching
// input feature-map address with adders only.
module fire_win_addr_gen
  import fire_pkg::*;
#(
  parameter int WOUT       = WOUT_DEF,
  parameter int CHIN       = CHIN_DEF,
  parameter int KERNEL_DIM = KDIM_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int IFM_BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int WIN  = WOUT + KERNEL_DIM - 1;
  localparam int CH_W = cnt_w(CHIN);
  localparam int K_W  = cnt_w(KERNEL_DIM);
  localparam int O_W  = cnt_w(WOUT);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(IFM_BASE);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WIN * CHIN);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(CHIN);
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(KERNEL_DIM * CHIN);
  localparam logic [CH_W-1:0]   CH_MAX    = CH_W'(CHIN - 1);
  localparam logic [K_W-1:0]    K_MAX     = K_W'(KERNEL_DIM - 1);
  localparam logic [O_W-1:0]    O_MAX     = O_W'(WOUT - 1);

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [K_W-1:0]    kx_q, kx_d, ky_q, ky_d;
  logic [O_W-1:0]    ocol_q, ocol_d, orow_q, orow_d;
  logic [ADDR_W-1:0] addr_q, addr_d, row_q, row_d, pix_q, pix_d;
  logic              ch_end, kx_end, ky_end, ocol_end, orow_end;

  assign ch_end   = (ch_q == CH_MAX);
  assign kx_end   = (kx_q == K_MAX);
  assign ky_end   = (ky_q == K_MAX);
  assign ocol_end = (ocol_q == O_MAX);
  assign orow_end = (orow_q == O_MAX);
  assign last     = ch_end && kx_end && ky_end && ocol_end && orow_end;
  assign addr     = addr_q;

  // kx and ch together span K*CHIN contiguous addresses, so only a ky or
  // pixel step needs a jump; row_q/pix_q hold the bases for those jumps.
  always_comb begin
    ch_d   = ch_q;
    kx_d   = kx_q;
    ky_d   = ky_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    addr_d = addr_q;
    row_d  = row_q;
    pix_d  = pix_q;
    if (clr) begin
      ch_d   = '0;
      kx_d   = '0;
      ky_d   = '0;
      ocol_d = '0;
      orow_d = '0;
      addr_d = BASE;
      row_d  = BASE;
      pix_d  = BASE;
    end else if (advance) begin
      ch_d   = ch_q + 1'b1;
      addr_d = addr_q + 1'b1;
      if (ch_end) begin
        ch_d = '0;
        kx_d = kx_q + 1'b1;
        if (kx_end) begin
          kx_d   = '0;
          ky_d   = ky_q + 1'b1;
          row_d  = row_q + ROW_STEP;
          addr_d = row_q + ROW_STEP;
          if (ky_end) begin
            ky_d   = '0;
            ocol_d = ocol_q + 1'b1;
            pix_d  = pix_q + (ocol_end ? WRAP_STEP : COL_STEP);
            row_d  = pix_d;
            addr_d = pix_d;
            if (ocol_end) begin
              ocol_d = '0;
              orow_d = orow_end ? '0 : orow_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q   <= '0;
      kx_q   <= '0;
      ky_q   <= '0;
      ocol_q <= '0;
      orow_q <= '0;
      addr_q <= BASE;
      row_q  <= BASE;
      pix_q  <= BASE;
    end else begin
      ch_q   <= ch_d;
      kx_q   <= kx_d;
      ky_q   <= ky_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
      addr_q <= addr_d;
      row_q  <= row_d;
      pix_q  <= pix_d;
    end
  end

endmodule

// File: rtl/fire_layer_seq.sv
// Sequences one fire expand layer: streams window reads to the MAC array,
// writes each finished pixel and reports completion after the output RAM ack.
module fire_layer_seq
  import fire_pkg::*;
#(
  parameter int WOUT       = WOUT_DEF,
  parameter int CHIN       = CHIN_DEF,
  parameter int KERNEL_DIM = KDIM_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int IFM_BASE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         ifm_ready,
  output logic                         ifm_rd,
  output logic [ADDR_W-1:0]            ifm_addr,
  output logic                         layer_en,
  input  logic                         layer_sample,
  output logic                         ofm_wr,
  output logic [$clog2(WOUT*WOUT)-1:0] ofm_addr,
  input  logic                         ram_feedback,
  output logic                         busy,
  output logic                         layer_finish
);

  localparam int PIX    = WOUT * WOUT;
  localparam int OFM_W  = $clog2(PIX);
  localparam int SCNT_W = $clog2(PIX + 1);
  localparam logic [SCNT_W-1:0] PIX_CNT = SCNT_W'(PIX);

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] samp_q;
  logic [OFM_W-1:0]  ofm_addr_q;
  logic              fb_q, layer_en_q, ofm_wr_q;
  logic              start_acc, gen_last;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  fire_win_addr_gen #(
    .WOUT      (WOUT),
    .CHIN      (CHIN),
    .KERNEL_DIM(KERNEL_DIM),
    .ADDR_W    (ADDR_W),
    .IFM_BASE  (IFM_BASE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .advance(ifm_rd),
    .addr   (ifm_addr),
    .last   (gen_last)
  );

  // ifm_ready is a per-cycle grant: a read (ifm_rd) and a counter step happen
  // only in a RUN cycle where ifm_ready is high; there is no retry later.
  always_comb begin
    state_d = state_q;
    ifm_rd  = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        ifm_rd = ifm_ready;
        if (ifm_ready && gen_last) state_d = DRAIN;
      end
      DRAIN:    if (samp_q == PIX_CNT) state_d = WAIT_ACK;
      WAIT_ACK: if (fb_q || ram_feedback) state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      samp_q     <= '0;
      ofm_addr_q <= '0;
      fb_q       <= 1'b0;
      layer_en_q <= 1'b0;
      ofm_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_en_q <= ifm_rd;
      ofm_wr_q   <= 1'b0;
      if (start_acc) begin
        samp_q     <= '0;
        ofm_addr_q <= '0;
        fb_q       <= 1'b0;
      end else if (state_q != IDLE) begin
        // An early ack is remembered until WAIT_ACK consumes it.
        if (state_q == WAIT_ACK) fb_q <= 1'b0;
        else if (ram_feedback)   fb_q <= 1'b1;
        if (layer_sample && (samp_q < PIX_CNT)) begin
          ofm_wr_q   <= 1'b1;
          ofm_addr_q <= samp_q[OFM_W-1:0];
          samp_q     <= samp_q + 1'b1;
        end
      end
    end
  end

  assign layer_en     = layer_en_q;
  assign ofm_wr       = ofm_wr_q;
  assign ofm_addr     = ofm_addr_q;
  assign busy         = (state_q == RUN) || (state_q == DRAIN) || (state_q == WAIT_ACK);
  assign layer_finish = (state_q == DONE);

endmodule

// File: tb/tb_fire_layer_seq.sv
// Bench for fire_layer_seq: a default-size instance for address order and
// mid-layer reset, a reduced instance for complete layers with stalls.
module tb_fire_layer_seq;

  localparam int S_WOUT = 4;
  localparam int S_CHIN = 8;
  localparam int S_K    = 3;
  localparam int S_BASE = 16;
  localparam int S_TAPS = S_K * S_K * S_CHIN;
  localparam int S_PIX  = S_WOUT * S_WOUT;
  localparam int D_TAPS = 3 * 3 * 112;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, d_start, d_ready, d_sample, d_fb;
  logic d_rd, d_en, d_wr, d_busy, d_fin;
  logic [15:0] d_addr;
  logic [5:0]  d_oaddr;

  logic rst_s, s_start, s_ready, s_sample, s_fb;
  logic s_rd, s_en, s_wr, s_busy, s_fin;
  logic [11:0] s_addr;
  logic [3:0]  s_oaddr;

  fire_layer_seq u_dflt (
    .clk(clk), .rst(rst_d), .start(d_start), .ifm_ready(d_ready),
    .ifm_rd(d_rd), .ifm_addr(d_addr), .layer_en(d_en),
    .layer_sample(d_sample), .ofm_wr(d_wr), .ofm_addr(d_oaddr),
    .ram_feedback(d_fb), .busy(d_busy), .layer_finish(d_fin)
  );

  fire_layer_seq #(
    .WOUT(S_WOUT), .CHIN(S_CHIN), .KERNEL_DIM(S_K), .ADDR_W(12), .IFM_BASE(S_BASE)
  ) u_small (
    .clk(clk), .rst(rst_s), .start(s_start), .ifm_ready(s_ready),
    .ifm_rd(s_rd), .ifm_addr(s_addr), .layer_en(s_en),
    .layer_sample(s_sample), .ofm_wr(s_wr), .ofm_addr(s_oaddr),
    .ram_feedback(s_fb), .busy(s_busy), .layer_finish(s_fin)
  );

  // scoreboard
  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ofm_q[$];
  bit prev_rd, wr_pend, in_run;
  int model_samp, wr_seen, rd_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int wout, input int chin, input int k,
                                  input int base, input int p, input int t);
    int win, orow, ocol, ky, kx, ch;
    win  = wout + k - 1;
    orow = p / wout;
    ocol = p % wout;
    ky   = t / (k * chin);
    kx   = (t / chin) % k;
    ch   = t % chin;
    return base + ((orow + ky) * win + ocol + kx) * chin + ch;
  endfunction

  // driver: one cycle on the reduced instance, checked at the falling edge
  task automatic cyc_s(input bit rdy, input bit smp, input bit fb, input bit st);
    logic [15:0] e;
    @(posedge clk); #1;
    s_ready = rdy; s_sample = smp; s_fb = fb; s_start = st;
    @(negedge clk);
    check("s_ifm_rd", 32'(s_rd), 32'(in_run && rdy));
    check("s_layer_en", 32'(s_en), 32'(prev_rd));
    check("s_ofm_wr", 32'(s_wr), 32'(wr_pend));
    if (s_rd) begin
      rd_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("s_ifm_addr", 32'(s_addr), 32'(e));
        if (exp_q.size() == 0) in_run = 1'b0;
      end
    end
    if (wr_pend) begin
      e = ofm_q.pop_front();
      if (s_wr) check("s_ofm_addr", 32'(s_oaddr), 32'(e));
    end
    if (s_wr) wr_seen++;
    prev_rd = s_rd;
    wr_pend = 1'b0;
    if (smp && model_samp < S_PIX) begin
      wr_pend = 1'b1;
      ofm_q.push_back(16'(model_samp));
      model_samp++;
    end
  endtask

  task automatic layer_s(input int stall_pct, input bit early_smp, input bit fb_in_run);
    int guard, pix_rd, c;
    bit rdy, smp, smp_next;
    exp_q.delete();
    ofm_q.delete();
    model_samp = 0; wr_seen = 0; rd_seen = 0;
    for (int p = 0; p < S_PIX; p++)
      for (int t = 0; t < S_TAPS; t++)
        exp_q.push_back(16'(exp_addr(S_WOUT, S_CHIN, S_K, S_BASE, p, t)));
    cyc_s(1'b0, 1'b0, 1'b0, 1'b1);
    in_run = 1'b1; pix_rd = 0; smp_next = 1'b0; guard = 0;
    while (in_run && guard < 20000) begin
      rdy = ($urandom_range(0, 99) >= stall_pct);
      smp = smp_next;
      smp_next = 1'b0;
      if (early_smp && rdy && exp_q.size() == 1) smp = 1'b1;
      cyc_s(rdy, smp, fb_in_run && guard == 40, guard == 100);
      if (guard == 0) begin
        check("s_ofm_addr_clr", 32'(s_oaddr), 0);
        check("s_fin_clear", 32'(s_fin), 0);
      end
      check("s_busy_run", 32'(s_busy), 1);
      if (s_rd) begin
        pix_rd++;
        if (pix_rd == S_TAPS) begin
          pix_rd = 0;
          smp_next = in_run || !early_smp;
        end
      end
      guard++;
    end
    check("s_run_bound", 32'(in_run), 0);
    c = 0;
    do begin
      c++;
      cyc_s(1'b0, smp_next, !fb_in_run && c == 1, 1'b0);
      smp_next = 1'b0;
      if (!s_fin) check("s_busy_drain", 32'(s_busy), 1);
    end while (!s_fin && c < 12);
    check("s_finish_lat", c, early_smp ? 3 : 4);
    check("s_busy_done", 32'(s_busy), 0);
    check("s_reads", rd_seen, S_TAPS * S_PIX);
    check("s_ofm_count", wr_seen, S_PIX);
    check("s_ofm_hold", 32'(s_oaddr), S_PIX - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd, cyc;
    logic [15:0] e;
    rst_d = 1'b1; d_start = 1'b0; d_ready = 1'b0; d_sample = 1'b0; d_fb = 1'b0;
    rst_s = 1'b1; s_start = 1'b0; s_ready = 1'b0; s_sample = 1'b0; s_fb = 1'b0;
    prev_rd = 1'b0; wr_pend = 1'b0; in_run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_d = 1'b0; rst_s = 1'b0;
    @(negedge clk);
    check("rst_d_rd", 32'(d_rd), 0);
    check("rst_d_en", 32'(d_en), 0);
    check("rst_d_wr", 32'(d_wr), 0);
    check("rst_d_oaddr", 32'(d_oaddr), 0);
    check("rst_d_busy", 32'(d_busy), 0);
    check("rst_d_fin", 32'(d_fin), 0);
    check("rst_s_rd", 32'(s_rd), 0);
    check("rst_s_en", 32'(s_en), 0);
    check("rst_s_wr", 32'(s_wr), 0);
    check("rst_s_oaddr", 32'(s_oaddr), 0);
    check("rst_s_busy", 32'(s_busy), 0);
    check("rst_s_fin", 32'(s_fin), 0);

    // default geometry: window order, then reset at read 30000
    for (int i = 0; i < 8 * D_TAPS + 40; i++)
      exp_q.push_back(16'(exp_addr(8, 112, 3, 0, i / D_TAPS, i % D_TAPS)));
    @(posedge clk); #1; d_start = 1'b1; d_ready = 1'b1;
    @(posedge clk); #1; d_start = 1'b0;
    rd = 0; cyc = 0; prev_rd = 1'b0;
    while (rd < 30000 && cyc < 40000) begin
      @(negedge clk);
      check("d_layer_en", 32'(d_en), 32'(prev_rd));
      if (d_rd) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("d_ifm_addr", 32'(d_addr), 32'(e));
        end
        if (rd == 336)   check("d_ky1_addr", 32'(d_addr), 1120);
        if (rd == 1008)  check("d_pix1_addr", 32'(d_addr), 112);
        if (rd == 8064)  check("d_pix8_addr", 32'(d_addr), 1120);
        rd++;
      end
      prev_rd = d_rd;
      @(posedge clk); #1;
      d_sample = (cyc == 10 || cyc == 20 || cyc == 30);
      cyc++;
    end
    check("d_read_bound", rd, 30000);
    check("d_busy_pre", 32'(d_busy), 1);
    check("d_oaddr_pre", 32'(d_oaddr), 2);
    rst_d = 1'b1;
    #1;
    check("d_mid_rst_rd", 32'(d_rd), 0);
    check("d_mid_rst_en", 32'(d_en), 0);
    check("d_mid_rst_wr", 32'(d_wr), 0);
    check("d_mid_rst_oaddr", 32'(d_oaddr), 0);
    check("d_mid_rst_busy", 32'(d_busy), 0);
    check("d_mid_rst_fin", 32'(d_fin), 0);
    @(posedge clk); #1; rst_d = 1'b0;
    @(posedge clk); #1; d_start = 1'b1;
    @(posedge clk); #1; d_start = 1'b0;
    @(negedge clk);
    check("d_restart_rd", 32'(d_rd), 1);
    check("d_restart_addr", 32'(d_addr), 0);
    check("d_restart_oaddr", 32'(d_oaddr), 0);
    check("d_restart_busy", 32'(d_busy), 1);
    d_ready = 1'b0;

    // reduced geometry: full layers
    prev_rd = 1'b0;
    exp_q.delete();
    layer_s(0, 1'b1, 1'b1);
    cyc_s(1'b0, 1'b1, 1'b0, 1'b0);
    cyc_s(1'b0, 1'b0, 1'b0, 1'b0);
    check("s_extra_fin", 32'(s_fin), 1);
    check("s_extra_oaddr", 32'(s_oaddr), S_PIX - 1);
    layer_s(50, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
